// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: LSU has priority, an IFU starvation guard caps LSU streaks,
// and one transaction is outstanding at a time with an optional per-transaction timeout.
module mem_arbiter #(
  parameter int MAX_LSU_STREAK = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        mem_reqValid,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam int SW = $clog2(MAX_LSU_STREAK + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [SW-1:0] STREAK_MAX   = SW'(MAX_LSU_STREAK);
  localparam logic [TW-1:0] TIMER_LAST   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [31:0]   TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, BUSY_IFU, BUSY_LSU} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] streak;
  logic [TW-1:0] timer;
  logic          grant_lsu, grant_ifu, timeout, done;

  function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] s);
    return (s >= STREAK_MAX) ? STREAK_MAX : s + 1'b1;
  endfunction

  // IFU overrides LSU priority only once the LSU has used up its streak while IFU waited
  assign grant_lsu = lsu_reqValid && !(ifu_reqValid && (streak == STREAK_MAX));
  assign grant_ifu = ifu_reqValid && !grant_lsu;
  assign timeout   = (TIMEOUT_CYCLES != 0) && (state != IDLE) && (timer == TIMER_LAST);
  assign done      = (state != IDLE) && (mem_respValid || timeout);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_lsu)      state_nxt = BUSY_LSU;
        else if (grant_ifu) state_nxt = BUSY_IFU;
      end
      BUSY_IFU, BUSY_LSU: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured only at grant and held for the whole transaction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak    <= '0;
      timer     <= '0;
      mem_addr  <= '0;
      mem_size  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (state == IDLE) begin
      timer <= '0;
      if (grant_lsu) begin
        mem_addr  <= lsu_addr;
        mem_size  <= lsu_size;
        mem_wen   <= lsu_wen;
        mem_wdata <= lsu_wdata;
        mem_wmask <= lsu_wmask;
        streak    <= ifu_reqValid ? streak_inc(streak) : '0;
      end else if (grant_ifu) begin
        mem_addr  <= ifu_addr;
        mem_size  <= 2'd2;
        mem_wen   <= 1'b0;
        mem_wdata <= '0;
        mem_wmask <= '0;
        streak    <= '0;
      end
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // A real response in the timeout cycle takes precedence over the forced error
  always_comb begin
    mem_reqValid  = (state != IDLE);
    ifu_respValid = (state == BUSY_IFU) && done;
    lsu_respValid = (state == BUSY_LSU) && done;
    err           = timeout && !mem_respValid;
    ifu_rdata     = '0;
    lsu_rdata     = '0;
    if (ifu_respValid) ifu_rdata = mem_respValid ? mem_rdata : TIMEOUT_DATA;
    if (lsu_respValid) lsu_rdata = mem_respValid ? mem_rdata : TIMEOUT_DATA;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int T    = 8;
  localparam int MAXS = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;
  logic        err;

  mem_arbiter #(.MAX_LSU_STREAK(MAXS), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
    .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
    .mem_reqValid(mem_reqValid), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_respValid(mem_respValid), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Model: who owns the port (0 none, 1 IFU, 2 LSU), what was granted, how long it has been busy
  int          owner, age, streak;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_size;
  logic        m_wen;
  logic [3:0]  m_wmask;
  bit          last_ifu_done, last_lsu_done;

  function automatic bit m_done();
    return (owner != 0) && (mem_respValid || age == T - 1);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      owner <= 0; age <= 0; streak <= 0;
    end else if (owner != 0) begin
      if (m_done()) owner <= 0;
      else          age <= age + 1;
    end else begin
      age <= 0;
      if (lsu_reqValid && !(ifu_reqValid && streak == MAXS)) begin
        owner <= 2;
        m_addr <= lsu_addr; m_size <= lsu_size; m_wen <= lsu_wen;
        m_wdata <= lsu_wdata; m_wmask <= lsu_wmask;
        streak <= ifu_reqValid ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
      end else if (ifu_reqValid) begin
        owner <= 1;
        m_addr <= ifu_addr; m_size <= 2'd2; m_wen <= 1'b0;
        m_wdata <= 32'h0; m_wmask <= 4'h0;
        streak <= 0;
      end
    end
  end

  always @(negedge clock) begin
    bit e_ifu, e_lsu;
    logic [31:0] e_data;
    if (reset) begin
      chk("rst_ifu_resp", ifu_respValid, 0);
      chk("rst_lsu_resp", lsu_respValid, 0);
      chk("rst_mem_req", mem_reqValid, 0);
      chk("rst_err", err, 0);
      last_ifu_done = 0;
      last_lsu_done = 0;
    end else begin
      e_ifu  = m_done() && owner == 1;
      e_lsu  = m_done() && owner == 2;
      e_data = mem_respValid ? mem_rdata : 32'hDEAD_BEEF;
      chk("ifu_resp", ifu_respValid, e_ifu);
      chk("lsu_resp", lsu_respValid, e_lsu);
      chk("ifu_rdata", ifu_rdata, e_ifu ? e_data : 32'h0);
      chk("lsu_rdata", lsu_rdata, e_lsu ? e_data : 32'h0);
      chk("err", err, (owner != 0) && (age == T - 1) && !mem_respValid);
      chk("mem_req", mem_reqValid, owner != 0);
      if (owner != 0) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_size", mem_size, m_size);
        chk("mem_wen", mem_wen, m_wen);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_wmask", mem_wmask, m_wmask);
      end
      last_ifu_done = e_ifu;
      last_lsu_done = e_lsu;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  initial begin
    logic [5:0] seq;
    int         n;
    reset = 1'b1;
    ifu_reqValid = 0; ifu_addr = 0;
    lsu_reqValid = 0; lsu_addr = 0; lsu_size = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_respValid = 0; mem_rdata = 0;
    tick(); tick();
    reset = 1'b0;
    at_neg();
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_size", mem_size, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_mem_wmask", mem_wmask, 0);

    // Single fetch, response three cycles after the request
    tick(); ifu_reqValid = 1; ifu_addr = 32'h8000_0000;
    at_neg(); chk("t1_req_idle", mem_reqValid, 0);
    tick(); at_neg();
    chk("t1_req", mem_reqValid, 1);
    chk("t1_addr", mem_addr, 32'h8000_0000);
    chk("t1_size", mem_size, 2);
    chk("t1_wen", mem_wen, 0);
    tick(); tick(); mem_respValid = 1; mem_rdata = 32'h13;
    at_neg(); chk("t1_resp", ifu_respValid, 1); chk("t1_rdata", ifu_rdata, 32'h13);
    tick(); ifu_reqValid = 0; mem_respValid = 0;
    at_neg(); chk("t1_back_idle", mem_reqValid, 0);

    // Simultaneous requests: LSU store first, IFU after one IDLE cycle
    tick(); ifu_reqValid = 1; ifu_addr = 32'h200;
    lsu_reqValid = 1; lsu_addr = 32'h100; lsu_size = 2; lsu_wen = 1;
    lsu_wdata = 32'hA5A5_A5A5; lsu_wmask = 4'hF;
    tick(); mem_respValid = 1; mem_rdata = 32'h0;
    at_neg();
    chk("t2_wen", mem_wen, 1);
    chk("t2_addr", mem_addr, 32'h100);
    chk("t2_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("t2_lsu_resp", lsu_respValid, 1);
    chk("t2_ifu_quiet", ifu_respValid, 0);
    tick(); lsu_reqValid = 0; mem_respValid = 0;
    at_neg(); chk("t2_gap", mem_reqValid, 0);
    tick(); mem_respValid = 1; mem_rdata = 32'h1234_5678;
    at_neg();
    chk("t2_ifu_addr", mem_addr, 32'h200);
    chk("t2_ifu_wen", mem_wen, 0);
    chk("t2_ifu_resp", ifu_respValid, 1);
    tick(); ifu_reqValid = 0; mem_respValid = 0;

    // Starvation guard: four LSU grants, one IFU, then LSU again
    tick(); ifu_reqValid = 1; lsu_reqValid = 1; mem_respValid = 1; mem_rdata = 32'h55;
    seq = '0; n = 0;
    for (int i = 0; i < 12; i++) begin
      at_neg();
      if (lsu_respValid) begin seq = {seq[4:0], 1'b1}; n++; end
      if (ifu_respValid) begin seq = {seq[4:0], 1'b0}; n++; end
      tick();
    end
    ifu_reqValid = 0; lsu_reqValid = 0; mem_respValid = 0;
    chk("t3_grant_count", n, 6);
    chk("t3_grant_order", seq, 6'b111101);

    // Timeout on an LSU load
    tick(); lsu_reqValid = 1; lsu_wen = 0; lsu_addr = 32'h300;
    for (int k = 1; k < T; k++) begin
      tick(); at_neg();
      chk("t4_wait_resp", lsu_respValid, 0);
      chk("t4_wait_err", err, 0);
    end
    tick(); at_neg();
    chk("t4_resp", lsu_respValid, 1);
    chk("t4_rdata", lsu_rdata, 32'hDEAD_BEEF);
    chk("t4_err", err, 1);
    tick(); lsu_reqValid = 0;
    at_neg(); chk("t4_idle", mem_reqValid, 0); chk("t4_err_gone", err, 0);

    // Asynchronous reset in the middle of a fetch
    tick(); ifu_reqValid = 1; ifu_addr = 32'h400;
    tick(); #2 reset = 1; ifu_reqValid = 0;
    #1;
    chk("t5_req_cleared", mem_reqValid, 0);
    chk("t5_addr_cleared", mem_addr, 0);
    chk("t5_no_resp", ifu_respValid, 0);
    tick(); reset = 0;
    at_neg(); chk("t5_after_rst", ifu_respValid, 0);
    tick(); ifu_reqValid = 1; ifu_addr = 32'h500;
    tick(); mem_respValid = 1; mem_rdata = 32'h77;
    at_neg(); chk("t5_addr", mem_addr, 32'h500); chk("t5_rdata", ifu_rdata, 32'h77);
    tick(); ifu_reqValid = 0; mem_respValid = 0;

    // Stray idle response, then fields changed while busy
    tick(); mem_respValid = 1;
    at_neg(); chk("t6_idle_lsu", lsu_respValid, 0); chk("t6_idle_ifu", ifu_respValid, 0);
    tick(); mem_respValid = 0; lsu_reqValid = 1; lsu_addr = 32'h600; lsu_size = 1;
    lsu_wen = 0; lsu_wmask = 4'h3; lsu_wdata = 32'h1234;
    tick(); lsu_addr = 32'h999; lsu_size = 0; lsu_wen = 1;
    tick(); mem_respValid = 1; mem_rdata = 32'hCAFE;
    at_neg();
    chk("t6_addr_held", mem_addr, 32'h600);
    chk("t6_size_held", mem_size, 1);
    chk("t6_wen_held", mem_wen, 0);
    chk("t6_rdata", lsu_rdata, 32'hCAFE);
    tick(); lsu_reqValid = 0; mem_respValid = 0;

    // Randomized traffic, alternating fast and slow memory phases
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (ifu_reqValid) begin
        if (last_ifu_done || $urandom_range(0, 31) == 0) ifu_reqValid = 0;
      end else if ($urandom_range(0, 1) == 1) begin
        ifu_reqValid = 1; ifu_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (lsu_reqValid) begin
        if (last_lsu_done || $urandom_range(0, 31) == 0) lsu_reqValid = 0;
        else if ($urandom_range(0, 7) == 0) lsu_addr = $urandom;
      end else if ($urandom_range(0, 1) == 1) begin
        lsu_reqValid = 1; lsu_addr = $urandom; lsu_size = 2'($urandom_range(0, 2));
        lsu_wen = 1'($urandom_range(0, 1)); lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
      end
      mem_respValid = ($urandom_range(0, ((i / 200) % 2 == 1) ? 15 : 3) == 0);
      mem_rdata = $urandom;
    end
    tick();
    ifu_reqValid = 0; lsu_reqValid = 0; mem_respValid = 0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
